// File: rtl/test_magnus_pkg.sv
// Shared constants and the Galois step for the 8-bit pattern generator.
package test_magnus_pkg;

    localparam int          LFSR_W    = 8;
    localparam logic [7:0]  LFSR_SEED = 8'h01;
    // x^8+x^6+x^5+x^4+1, right-shifting Galois form; period 255
    localparam logic [7:0]  LFSR_MASK = 8'hB8;

    function automatic logic [LFSR_W-1:0] lfsr_next(
        input logic [LFSR_W-1:0] s,
        input logic [LFSR_W-1:0] mask = LFSR_MASK
    );
        lfsr_next = (s >> 1) ^ (s[0] ? mask : '0);
    endfunction

endpackage

// File: rtl/lfsr8_galois.sv
// Galois LFSR state register with synchronous reset and all-zero lock-up recovery.
module lfsr8_galois
    import test_magnus_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED,
    parameter logic [LFSR_W-1:0] MASK = LFSR_MASK
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] s_q;
    logic [LFSR_W-1:0] s_d;

    always_comb begin
        s_d = s_q;
        if (en) begin
            // All-zero is a fixed point of the LFSR; only an upset can land here.
            s_d = (s_q == '0) ? SEED : lfsr_next(s_q, MASK);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) s_q <= SEED;
        else     s_q <= s_d;
    end

    assign q = s_q;

endmodule

// File: rtl/test_magnus_core.sv
// Tile wrapper: io_in carries clk/rst/en, io_out shows the registered LFSR state.
module test_magnus_core
    import test_magnus_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_SEED,
    parameter logic [LFSR_W-1:0] MASK = LFSR_MASK
) (
    input  logic [7:0] io_in,
    output logic [7:0] io_out
);

    logic clk;
    logic rst;
    logic en;
    logic unused_pins;

    assign clk = io_in[0];
    assign rst = io_in[1];
    assign en  = io_in[2];

    // Harness ties these low; they are deliberately not connected to anything.
    assign unused_pins = &{1'b0, io_in[7:3]};

    lfsr8_galois #(
        .SEED (SEED),
        .MASK (MASK)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .q   (io_out)
    );

endmodule

// File: tb/tb_test_magnus_core.sv
// Bench for test_magnus_core: directed table, period/reset sequences, randomized run vs model.
module tb_test_magnus_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [4:0] unused = 5'd0;
    logic [7:0] io_in;
    logic [7:0] io_out;

    int tests = 0;
    int fails = 0;

    assign io_in = {unused, en, rst, clk};

    test_magnus_core dut (
        .io_in  (io_in),
        .io_out (io_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] seq[255];

    function automatic void add(logic r, logic e, logic [7:0] x, string n);
        vec_t v;
        v.rst = r; v.en = e; v.exp = x; v.name = n;
        vecs.push_back(v);
    endfunction

    task automatic check(string name, logic [7:0] exp);
        tests++;
        if (io_out !== exp) begin
            fails++;
            $display("FAIL %s: io_out=%02h expected=%02h", name, io_out, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample just after the rising edge.
    task automatic cyc(logic r, logic e, logic [4:0] u);
        @(negedge clk);
        rst = r; en = e; unused = u;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit seen[256];
        int idx;
        logic [7:0] s;

        // Reference orbit of the polynomial, computed once from the seed.
        s = 8'h01;
        for (int i = 0; i < 255; i++) begin
            seq[i] = s;
            s = {1'b0, s[7:1]} ^ (s[0] ? 8'hB8 : 8'h00);
        end

        // Reset, stepping, hold, resume; unused pins toggle randomly throughout.
        add(1, 0, 8'h01, "reset0");
        add(1, 0, 8'h01, "reset1");
        add(1, 1, 8'h01, "reset_en");
        add(0, 1, 8'hB8, "step1");
        add(0, 1, 8'h5C, "step2");
        add(0, 1, 8'h2E, "step3");
        for (int i = 0; i < 10; i++) add(0, 0, 8'h2E, "hold");
        add(0, 1, 8'h17, "step4");
        add(0, 1, 8'hB3, "step5");
        add(0, 1, 8'hE1, "step6");
        add(0, 1, 8'hC8, "step7");
        add(0, 0, 8'hC8, "hold_end");

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].rst, vecs[i].en, 5'($urandom));
            check(vecs[i].name, vecs[i].exp);
        end

        // Full period: 255 distinct nonzero values, back to seed.
        cyc(1, 0, 5'd0);
        check("period_reset", 8'h01);
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[8'h01] = 1'b1;
        for (int i = 1; i < 255; i++) begin
            cyc(0, 1, 5'd0);
            tests++;
            if (io_out === 8'h00 || $isunknown(io_out) || seen[io_out]) begin
                fails++;
                $display("FAIL period_distinct step %0d: io_out=%02h repeated or zero", i, io_out);
            end else begin
                seen[io_out] = 1'b1;
            end
        end
        cyc(0, 1, 5'd0);
        check("period_wrap", 8'h01);

        // Mid-run reset with en held high.
        cyc(1, 0, 5'd0);
        for (int i = 0; i < 20; i++) cyc(0, 1, 5'($urandom));
        check("mid_run_20", seq[20]);
        cyc(1, 1, 5'd0);
        check("mid_reset", 8'h01);
        cyc(0, 1, 5'd0);
        check("mid_release", 8'hB8);

        // Randomized run against the orbit-index model.
        cyc(1, 0, 5'd0);
        idx = 0;
        for (int i = 0; i < 600; i++) begin
            logic r, e;
            r = ($urandom_range(0, 99) < 4);
            e = $urandom_range(0, 1) == 1;
            cyc(r, e, 5'($urandom));
            if (r)      idx = 0;
            else if (e) idx = (idx + 1) % 255;
            check("random", seq[idx]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
